// File: rtl/pwr_seq_pkg.sv
// Shared definitions for the power/reset sequencer: state encoding,
// default timing and the per-state output decode.
package pwr_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_STAB  = 3'd1,
      ST_PADEN = 3'd2,
      ST_OUTEN = 3'd3,
      ST_PREL  = 3'd4,
      ST_RUN   = 3'd5,
      ST_SWRST = 3'd6
   } state_e;

   localparam int unsigned DEF_STAB_CYCLES  = 1024;
   localparam int unsigned DEF_GAP_CYCLES   = 16;
   localparam int unsigned DEF_SWRST_CYCLES = 32;
   localparam int unsigned DEF_CNT_W        = 16;

   typedef struct packed {
      logic pad_ie;
      logic pad_oe;
      logic periph_rst;
      logic core_rst;
      logic seq_done;
   } seq_out_t;

   // Everything disabled, everything held in reset.
   localparam seq_out_t OUT_RESET = '{pad_ie: 1'b0, pad_oe: 1'b0, periph_rst: 1'b1,
                                      core_rst: 1'b1, seq_done: 1'b0};

   // Output levels that each state drives (registered by the caller).
   function automatic seq_out_t state_outputs(input state_e st);
      seq_out_t o;
      o = OUT_RESET;
      case (st)
         ST_IDLE, ST_STAB: o = OUT_RESET;
         ST_PADEN: begin
            o.pad_ie = 1'b1;
         end
         ST_OUTEN: begin
            o.pad_ie = 1'b1;
            o.pad_oe = 1'b1;
         end
         ST_PREL: begin
            o.pad_ie     = 1'b1;
            o.pad_oe     = 1'b1;
            o.periph_rst = 1'b0;
         end
         ST_RUN: begin
            o.pad_ie     = 1'b1;
            o.pad_oe     = 1'b1;
            o.periph_rst = 1'b0;
            o.core_rst   = 1'b0;
            o.seq_done   = 1'b1;
         end
         ST_SWRST: begin
            o.pad_ie     = 1'b1;
            o.pad_oe     = 1'b1;
            o.periph_rst = 1'b0;
            o.core_rst   = 1'b1;
            o.seq_done   = 1'b0;
         end
         default: o = OUT_RESET;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer, synchronous active-high reset to 0.
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic ff1_r;
   logic ff2_r;

   // Two-stage capture of the asynchronous input into the clk domain.
   always_ff @(posedge clk) begin
      if (rst) begin
         ff1_r <= 1'b0;
         ff2_r <= 1'b0;
      end else begin
         ff1_r <= d;
         ff2_r <= ff1_r;
      end
   end

   assign q = ff2_r;

endmodule

// File: rtl/pwr_seq_ctrl.sv
// Power/reset sequencer: waits for stable IO power and PLL lock, then
// releases pad input enable, pad output enable, peripheral reset and core
// reset in that order. Any loss of power or lock drops everything at once.
module pwr_seq_ctrl
   import pwr_seq_pkg::*;
#(
   parameter int unsigned STAB_CYCLES  = DEF_STAB_CYCLES,
   parameter int unsigned GAP_CYCLES   = DEF_GAP_CYCLES,
   parameter int unsigned SWRST_CYCLES = DEF_SWRST_CYCLES,
   parameter int unsigned CNT_W        = DEF_CNT_W
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       poc_ok_i,
   input  logic       pll_lock_i,
   input  logic       sw_rst_req_i,
   output logic       pad_ie_o,
   output logic       pad_oe_o,
   output logic       periph_rst_o,
   output logic       core_rst_o,
   output logic       seq_done_o,
   output logic [2:0] state_o
);

   localparam logic [CNT_W-1:0] STAB_LAST  = CNT_W'(STAB_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] SWRST_LAST = CNT_W'(SWRST_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

   logic             poc_sync_s;
   logic             pll_sync_s;
   logic             pwr_ok_s;
   state_e           state_r;
   state_e           state_nxt_s;
   logic [CNT_W-1:0] cnt_r;
   seq_out_t         out_r;

   sync_2ff u_sync_poc (.clk(clk), .rst(rst), .d(poc_ok_i),   .q(poc_sync_s));
   sync_2ff u_sync_pll (.clk(clk), .rst(rst), .d(pll_lock_i), .q(pll_sync_s));

   assign pwr_ok_s = poc_sync_s & pll_sync_s;

   // Next-state selection; power loss outranks every other transition.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (pwr_ok_s) state_nxt_s = ST_STAB;
            else          state_nxt_s = ST_IDLE;
         end
         ST_STAB: begin
            if (!pwr_ok_s)               state_nxt_s = ST_IDLE;
            else if (cnt_r == STAB_LAST) state_nxt_s = ST_PADEN;
            else                         state_nxt_s = ST_STAB;
         end
         ST_PADEN: begin
            if (!pwr_ok_s)              state_nxt_s = ST_IDLE;
            else if (cnt_r == GAP_LAST) state_nxt_s = ST_OUTEN;
            else                        state_nxt_s = ST_PADEN;
         end
         ST_OUTEN: begin
            if (!pwr_ok_s)              state_nxt_s = ST_IDLE;
            else if (cnt_r == GAP_LAST) state_nxt_s = ST_PREL;
            else                        state_nxt_s = ST_OUTEN;
         end
         ST_PREL: begin
            if (!pwr_ok_s)              state_nxt_s = ST_IDLE;
            else if (cnt_r == GAP_LAST) state_nxt_s = ST_RUN;
            else                        state_nxt_s = ST_PREL;
         end
         ST_RUN: begin
            if (!pwr_ok_s)         state_nxt_s = ST_IDLE;
            else if (sw_rst_req_i) state_nxt_s = ST_SWRST;
            else                   state_nxt_s = ST_RUN;
         end
         ST_SWRST: begin
            if (!pwr_ok_s)                state_nxt_s = ST_IDLE;
            else if (cnt_r == SWRST_LAST) state_nxt_s = ST_RUN;
            else                          state_nxt_s = ST_SWRST;
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_r <= ST_IDLE;
      else     state_r <= state_nxt_s;
   end

   // Dwell counter: cleared on every state change, saturates instead of wrapping.
   always_ff @(posedge clk) begin
      if (rst)                         cnt_r <= {CNT_W{1'b0}};
      else if (state_nxt_s != state_r) cnt_r <= {CNT_W{1'b0}};
      else if (cnt_r != CNT_MAX)       cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      else                             cnt_r <= cnt_r;
   end

   // Output register: levels follow the state one cycle later, glitch-free.
   always_ff @(posedge clk) begin
      if (rst) out_r <= OUT_RESET;
      else     out_r <= state_outputs(state_r);
   end

   assign pad_ie_o     = out_r.pad_ie;
   assign pad_oe_o     = out_r.pad_oe;
   assign periph_rst_o = out_r.periph_rst;
   assign core_rst_o   = out_r.core_rst;
   assign seq_done_o   = out_r.seq_done;
   assign state_o      = state_r;

endmodule

// File: tb/tb_pwr_seq_ctrl.sv
// Bench for pwr_seq_ctrl: directed scenarios followed by random power,
// lock, reset and software-reset activity, all compared each cycle against
// an elapsed-time reference model.
module tb_pwr_seq_ctrl;

   localparam int S  = 8;
   localparam int G  = 4;
   localparam int SW = 5;

   logic       clk = 1'b0;
   logic       rst, poc, pll, swreq;
   logic       pad_ie_o, pad_oe_o, periph_rst_o, core_rst_o, seq_done_o;
   logic [2:0] state_o;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: time since leaving idle plus remaining sw-reset time.
   int m_e  = -1;
   int m_sw = 0;
   bit m_p1 = 1'b0, m_p2 = 1'b0;
   bit m_ie = 1'b0, m_oe = 1'b0, m_prst = 1'b1, m_crst = 1'b1, m_done = 1'b0;

   pwr_seq_ctrl #(.STAB_CYCLES(S), .GAP_CYCLES(G), .SWRST_CYCLES(SW), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .poc_ok_i(poc), .pll_lock_i(pll), .sw_rst_req_i(swreq),
      .pad_ie_o(pad_ie_o), .pad_oe_o(pad_oe_o), .periph_rst_o(periph_rst_o),
      .core_rst_o(core_rst_o), .seq_done_o(seq_done_o), .state_o(state_o)
   );

   always #5 clk = ~clk;

   function automatic int m_state();
      if (m_e < 0)           return 0;
      else if (m_sw > 0)     return 6;
      else if (m_e < S)      return 1;
      else if (m_e < S + G)  return 2;
      else if (m_e < S+2*G)  return 3;
      else if (m_e < S+3*G)  return 4;
      else                   return 5;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_edge();
      int st;
      st = m_state();
      if (rst) begin
         m_e = -1; m_sw = 0; m_p1 = 1'b0; m_p2 = 1'b0;
         m_ie = 1'b0; m_oe = 1'b0; m_prst = 1'b1; m_crst = 1'b1; m_done = 1'b0;
      end else begin
         m_ie   = (st >= 2);
         m_oe   = (st >= 3);
         m_prst = (st <= 1) || (st == 2) || (st == 3);
         m_crst = (st != 5);
         m_done = (st == 5);
         if (m_e < 0)                  m_e = m_p2 ? 0 : -1;
         else if (!m_p2) begin         m_e = -1; m_sw = 0; end
         else if (st == 5 && swreq)    m_sw = SW;
         else if (m_sw > 0)            m_sw--;
         else if (m_e < 100000)        m_e++;
         m_p2 = m_p1;
         m_p1 = poc & pll;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      chk("state_o",      state_o,      m_state());
      chk("pad_ie_o",     pad_ie_o,     m_ie);
      chk("pad_oe_o",     pad_oe_o,     m_oe);
      chk("periph_rst_o", periph_rst_o, m_prst);
      chk("core_rst_o",   core_rst_o,   m_crst);
      chk("seq_done_o",   seq_done_o,   m_done);
   endtask

   initial begin
      int r_ie, r_oe, r_prel, r_core, rec, cnt;
      rst = 1'b1; poc = 1'b0; pll = 1'b0; swreq = 1'b0;

      // Reset, then hold with no power.
      repeat (3) step();
      rst = 1'b0;
      repeat (20) step();

      // Power up: measure release times from the first powered cycle.
      poc = 1'b1; pll = 1'b1;
      r_ie = -1; r_oe = -1; r_prel = -1; r_core = -1;
      for (int k = 0; k < 30; k++) begin
         step();
         if (pad_ie_o     && r_ie   < 0) r_ie   = k + 1;
         if (pad_oe_o     && r_oe   < 0) r_oe   = k + 1;
         if (!periph_rst_o && r_prel < 0) r_prel = k + 1;
         if (!core_rst_o  && r_core < 0) r_core = k + 1;
      end
      chk("t_pad_ie",   r_ie,   12);
      chk("t_pad_oe",   r_oe,   16);
      chk("t_periph",   r_prel, 20);
      chk("t_core",     r_core, 24);
      chk("run_done",   seq_done_o, 1'b1);

      // Lock glitch at stabilisation count 5.
      rst = 1'b1; step(); rst = 1'b0;
      for (int i = 0; i < 50 && !(m_state() == 1 && m_e == 5); i++) step();
      chk("reach_stab5", state_o, 3'd1);
      pll = 1'b0; step(); pll = 1'b1;
      rec = -1;
      for (int k = 0; k < 40; k++) begin
         step();
         if (pad_ie_o && rec < 0) rec = k + 1;
      end
      chk("glitch_gap", (rec >= 8) ? 1 : 0, 1);

      // Software reset pulse, with a second ignored request mid-pulse.
      swreq = 1'b1; step(); swreq = 1'b0;
      cnt = 0;
      for (int j = 0; j < 12; j++) begin
         swreq = (j == 2);
         step();
         if (core_rst_o) cnt++;
      end
      swreq = 1'b0;
      chk("swrst_len", cnt, SW);

      // One-cycle power loss in RUN.
      poc = 1'b0; step(); poc = 1'b1;
      repeat (3) step();
      chk("loss_ie",   pad_ie_o,     1'b0);
      chk("loss_core", core_rst_o,   1'b1);
      chk("loss_prst", periph_rst_o, 1'b1);
      repeat (40) step();
      chk("replay_done", seq_done_o, 1'b1);

      // Reset asserted during OUTEN.
      rst = 1'b1; step(); rst = 1'b0;
      for (int i = 0; i < 60 && m_state() != 3; i++) step();
      chk("reach_outen", state_o, 3'd3);
      rst = 1'b1; step();
      chk("rst_state", state_o,    3'd0);
      chk("rst_ie",    pad_ie_o,   1'b0);
      chk("rst_core",  core_rst_o, 1'b1);
      rst = 1'b0;

      // Random activity.
      for (int k = 0; k < 3000; k++) begin
         rst   = ($urandom_range(299, 0) == 0);
         poc   = ($urandom_range(59, 0) != 0);
         pll   = ($urandom_range(59, 0) != 0);
         swreq = ($urandom_range(9, 0) == 0);
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
